// File: rtl/unit_test_sequencer.sv
// On-chip vector sequencer: issues stored stimulus to each enabled unit channel in turn,
// compares the response under a mask and reports error count, first error and a verdict.
module unit_test_sequencer #(
    parameter  int WIDTH   = 32,
    parameter  int NCH     = 4,
    parameter  int DEPTH   = 16,
    parameter  int TIMEOUT = 64,
    localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [CW-1:0]        cfg_ch,
    input  logic [AW-1:0]        cfg_addr,
    input  logic [WIDTH-1:0]     cfg_stim,
    input  logic [WIDTH-1:0]     cfg_exp,
    input  logic [WIDTH-1:0]     cfg_mask,
    input  logic                 start,
    input  logic [NCH-1:0]       ch_en,
    input  logic [AW:0]          num_vec,
    output logic [NCH-1:0]       stim_valid,
    output logic [WIDTH-1:0]     stim_data,
    input  logic [NCH-1:0]       stim_ready,
    input  logic [NCH-1:0]       resp_valid,
    input  logic [NCH*WIDTH-1:0] resp_data,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [15:0]          err_count,
    output logic                 first_err_valid,
    output logic [CW-1:0]        first_err_ch,
    output logic [AW-1:0]        first_err_addr
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEL   = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] stim_mem [NCH][DEPTH];
    logic [WIDTH-1:0] exp_mem  [NCH][DEPTH];
    logic [WIDTH-1:0] mask_mem [NCH][DEPTH];

    logic [NCH-1:0]   en_q;
    logic [NCH-1:0]   ran_q;
    logic [AW:0]      nvec_q;
    logic [CW-1:0]    ch_q;
    logic [AW-1:0]    idx_q;
    logic [TW-1:0]    cnt_q;
    logic             tmo_q;
    logic [WIDTH-1:0] resp_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [15:0]      err_q;
    logic             fev_q;
    logic [CW-1:0]    fech_q;
    logic [AW-1:0]    feaddr_q;

    logic [NCH-1:0]   pend_s;
    logic [CW-1:0]    sel_ch_s;
    logic [WIDTH-1:0] resp_sel_s;
    logic [WIDTH-1:0] cur_stim_s;
    logic [WIDTH-1:0] cur_exp_s;
    logic [WIDTH-1:0] cur_mask_s;
    logic [AW:0]      idx_nxt_s;
    logic             last_s;
    logic             err_s;
    logic [AW:0]      nvec_clamp_s;

    // Vector store; writes are locked out for the whole run.
    always_ff @(posedge clk) begin
        if (cfg_we && !busy_q && (int'(cfg_ch) < NCH)) begin
            stim_mem[cfg_ch][cfg_addr] <= cfg_stim;
            exp_mem[cfg_ch][cfg_addr]  <= cfg_exp;
            mask_mem[cfg_ch][cfg_addr] <= cfg_mask;
        end
    end

    // Channel selection, response slice and compare datapath.
    always_comb begin
        pend_s     = en_q & ~ran_q;
        sel_ch_s   = '0;
        resp_sel_s = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            sel_ch_s = pend_s[k] ? CW'(k) : sel_ch_s;
        end
        for (int k = 0; k < NCH; k++) begin
            resp_sel_s = (ch_q == CW'(k)) ? resp_data[k*WIDTH +: WIDTH] : resp_sel_s;
        end
        cur_stim_s   = stim_mem[ch_q][idx_q];
        cur_exp_s    = exp_mem[ch_q][idx_q];
        cur_mask_s   = mask_mem[ch_q][idx_q];
        idx_nxt_s    = {1'b0, idx_q} + {{AW{1'b0}}, 1'b1};
        last_s       = !(idx_nxt_s < nvec_q);
        err_s        = tmo_q || (((resp_q ^ cur_exp_s) & cur_mask_s) != '0);
        nvec_clamp_s = (num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_vec;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = start ? S_SEL : S_IDLE;
            S_SEL:   state_d = ((pend_s == '0) || (nvec_q == '0)) ? S_DONE : S_ISSUE;
            S_ISSUE: state_d = stim_ready[ch_q] ? S_WAIT : S_ISSUE;
            S_WAIT:  state_d = (resp_valid[ch_q] || (cnt_q == TW'(TIMEOUT - 1))) ? S_CHECK : S_WAIT;
            S_CHECK: state_d = last_s ? S_SEL : S_ISSUE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Stimulus outputs decode straight from state so they drop with reset.
    always_comb begin
        stim_valid = (state_q == S_ISSUE) ? (NCH'(1) << ch_q) : '0;
        stim_data  = (state_q == S_ISSUE) ? cur_stim_s : '0;
    end

    // Run bookkeeping: capture, vector stepping, timeout, error recording, verdict.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_q     <= '0;
            ran_q    <= '0;
            nvec_q   <= '0;
            ch_q     <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            tmo_q    <= 1'b0;
            resp_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= 16'h0000;
            fev_q    <= 1'b0;
            fech_q   <= '0;
            feaddr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        en_q     <= ch_en;
                        nvec_q   <= nvec_clamp_s;
                        ran_q    <= '0;
                        err_q    <= 16'h0000;
                        fev_q    <= 1'b0;
                        fech_q   <= '0;
                        feaddr_q <= '0;
                        done_q   <= 1'b0;
                        pass_q   <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                S_SEL: begin
                    ch_q  <= sel_ch_s;
                    idx_q <= '0;
                end
                S_ISSUE: begin
                    cnt_q <= '0;
                    tmo_q <= 1'b0;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + TW'(1);
                    if (resp_valid[ch_q]) begin
                        resp_q <= resp_sel_s;
                    end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                        tmo_q <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (err_s) begin
                        err_q <= (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
                        if (!fev_q) begin
                            fev_q    <= 1'b1;
                            fech_q   <= ch_q;
                            feaddr_q <= idx_q;
                        end
                    end
                    if (last_s) begin
                        ran_q[ch_q] <= 1'b1;
                    end else begin
                        idx_q <= idx_q + AW'(1);
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    pass_q <= (err_q == 16'h0000);
                end
                default: begin
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_valid = fev_q;
    assign first_err_ch    = fech_q;
    assign first_err_addr  = feaddr_q;

endmodule

// File: tb/tb_unit_test_sequencer.sv
// Bench for unit_test_sequencer: per-channel unit responders (output = stim + 3) and a
// run-level reference model predicting errors, first error, issue order and busy duration.
module tb_unit_test_sequencer;

    localparam int WIDTH   = 32;
    localparam int NCH     = 4;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 64;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 cfg_we;
    logic [1:0]           cfg_ch;
    logic [3:0]           cfg_addr;
    logic [WIDTH-1:0]     cfg_stim, cfg_exp, cfg_mask;
    logic                 start;
    logic [NCH-1:0]       ch_en;
    logic [4:0]           num_vec;
    logic [NCH-1:0]       stim_valid;
    logic [WIDTH-1:0]     stim_data;
    logic [NCH-1:0]       stim_ready;
    logic [NCH-1:0]       resp_valid;
    logic [NCH*WIDTH-1:0] resp_data;
    logic                 busy, done, pass;
    logic [15:0]          err_count;
    logic                 first_err_valid;
    logic [1:0]           first_err_ch;
    logic [3:0]           first_err_addr;

    unit_test_sequencer #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr),
        .cfg_stim(cfg_stim), .cfg_exp(cfg_exp), .cfg_mask(cfg_mask), .start(start),
        .ch_en(ch_en), .num_vec(num_vec), .stim_valid(stim_valid), .stim_data(stim_data),
        .stim_ready(stim_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_valid(first_err_valid), .first_err_ch(first_err_ch),
        .first_err_addr(first_err_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [WIDTH-1:0] m_stim [NCH][DEPTH];
    logic [WIDTH-1:0] m_exp  [NCH][DEPTH];
    logic [WIDTH-1:0] m_mask [NCH][DEPTH];
    int  rlat [NCH];
    int  rdel [NCH];
    int  vcnt [NCH];
    int  wcnt [NCH];
    bit  acc_flag [NCH];
    logic [WIDTH-1:0] hold [NCH];
    logic [NCH-1:0] cur_en = '0;
    bit  noise_en = 1'b0;
    logic [35:0] obs_q [$];
    logic [35:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Unit responders: ready after rlat stall cycles, response rdel cycles after accept (0 = never).
    initial begin
        stim_ready = '0;
        resp_valid = '0;
        resp_data  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stim_ready = '0;
                resp_valid = '0;
                for (int k = 0; k < NCH; k++) begin
                    vcnt[k] = 0; wcnt[k] = 0; acc_flag[k] = 1'b0;
                end
            end else begin
                chk("stim_valid_onehot", $onehot0(stim_valid), 1);
                for (int k = 0; k < NCH; k++) begin
                    resp_valid[k] = 1'b0;
                    if (acc_flag[k]) begin
                        acc_flag[k] = 1'b0;
                        wcnt[k] = rdel[k];
                    end
                    if (wcnt[k] > 0) begin
                        wcnt[k]--;
                        if (wcnt[k] == 0) begin
                            resp_valid[k] = 1'b1;
                            resp_data[k*WIDTH +: WIDTH] = hold[k] + 32'd3;
                        end
                    end else if (noise_en && !cur_en[k]) begin
                        resp_valid[k] = 1'($urandom_range(0, 1));
                        resp_data[k*WIDTH +: WIDTH] = $urandom;
                    end
                    if (stim_valid[k]) begin
                        vcnt[k]++;
                        if (vcnt[k] == 1) hold[k] = stim_data;
                        else chk("stim_hold", stim_data, hold[k]);
                        stim_ready[k] = (vcnt[k] > rlat[k]);
                        if (stim_ready[k]) begin
                            acc_flag[k] = 1'b1;
                            obs_q.push_back({4'(k), stim_data});
                        end
                    end else begin
                        vcnt[k] = 0;
                        stim_ready[k] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wr(input int c, input int a, input logic [31:0] s, input logic [31:0] e,
                      input logic [31:0] m);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = 2'(c); cfg_addr = 4'(a);
        cfg_stim = s; cfg_exp = e; cfg_mask = m;
        m_stim[c][a] = s; m_exp[c][a] = e; m_mask[c][a] = m;
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    // Reference model: walk enabled channels in ascending order, every vector in index order.
    task automatic model(input logic [3:0] en, input int nv, output int errs, output bit fev,
                         output int fch, output int fad, output int cyc);
        int n;
        int w;
        bit bad;
        n = (nv > DEPTH) ? DEPTH : nv;
        errs = 0; fev = 1'b0; fch = 0; fad = 0; cyc = 2;
        exp_q.delete();
        if (n > 0) begin
            for (int c = 0; c < NCH; c++) begin
                if (en[c]) begin
                    cyc += 1;
                    for (int v = 0; v < n; v++) begin
                        w = (rdel[c] > 0 && rdel[c] <= TIMEOUT) ? rdel[c] : TIMEOUT;
                        cyc += rlat[c] + 1 + w + 1;
                        exp_q.push_back({4'(c), m_stim[c][v]});
                        bad = (w == TIMEOUT && rdel[c] != TIMEOUT) ||
                              ((((m_stim[c][v] + 32'd3) ^ m_exp[c][v]) & m_mask[c][v]) != 32'd0);
                        if (bad) begin
                            errs++;
                            if (!fev) begin fev = 1'b1; fch = c; fad = v; end
                        end
                    end
                end
            end
        end
    endtask

    task automatic run(input logic [3:0] en, input int nv, input bit poke);
        int errs, fch, fad, cyc, ecyc;
        bit fev;
        model(en, nv, errs, fev, fch, fad, ecyc);
        obs_q.delete();
        cur_en = en;
        @(negedge clk);
        ch_en = en; num_vec = 5'(nv); start = 1'b1;
        @(negedge clk);
        start = 1'b0; ch_en = 4'($urandom); num_vec = 5'($urandom);
        chk("done_cleared_on_start", done, 0);
        cyc = 0;
        while (busy === 1'b1 && cyc < 20000) begin
            cyc++;
            if (poke && cyc == 5) begin
                cfg_we = 1'b1; cfg_ch = 2'd1; cfg_addr = 4'd0;
                cfg_stim = 32'hDEAD_BEEF; cfg_exp = 32'h0; cfg_mask = 32'hFFFF_FFFF;
                start = 1'b1; ch_en = 4'hF; num_vec = 5'd16;
            end else begin
                cfg_we = 1'b0; start = 1'b0;
            end
            @(negedge clk);
        end
        cfg_we = 1'b0; start = 1'b0;
        chk("busy_dropped", busy, 0);
        chk("busy_cycles", cyc, ecyc);
        chk("done", done, 1);
        chk("pass", pass, (errs == 0));
        chk("err_count", err_count, errs);
        chk("first_err_valid", first_err_valid, fev);
        if (fev) begin
            chk("first_err_ch", first_err_ch, fch);
            chk("first_err_addr", first_err_addr, fad);
        end
        chk("stim_valid_idle", stim_valid, 0);
        chk("issue_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk("issue_order", obs_q[i], exp_q[i]);
    endtask

    initial begin
        int found;
        reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0;
        cfg_stim = '0; cfg_exp = '0; cfg_mask = '0; start = 1'b0; ch_en = '0; num_vec = '0;
        for (int k = 0; k < NCH; k++) begin rlat[k] = 0; rdel[k] = 1; end
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_first_err", {first_err_valid, first_err_ch, first_err_addr}, 0);
        chk("rst_stim", {stim_valid, stim_data}, 0);
        reset = 1'b0;

        // Basic pass, single mismatch, masked compare
        for (int v = 0; v < 3; v++) wr(0, v, 32'd5, 32'd8, 32'hFFFF_FFFF);
        run(4'b0001, 3, 1'b0);
        wr(0, 1, 32'd5, 32'd9, 32'hFFFF_FFFF);
        run(4'b0001, 3, 1'b0);
        wr(0, 0, 32'h1234_56FC, 32'h0000_00FF, 32'h0000_00FF);
        run(4'b0001, 1, 1'b0);

        // Empty runs: no channels, zero vectors
        run(4'b0000, 3, 1'b0);
        run(4'b1111, 0, 1'b0);

        // Timeouts on ch2, then ch3 still runs
        rdel[2] = 0;
        for (int v = 0; v < 2; v++) begin
            wr(2, v, 32'(v + 100), 32'(v + 103), 32'hFFFF_FFFF);
            wr(3, v, 32'(v + 200), 32'(v + 203), 32'hFFFF_FFFF);
        end
        run(4'b1100, 2, 1'b0);
        rdel[2] = 1;

        // Stall on ch3 with config writes and start attempted mid-run, then rerun
        rlat[3] = 10;
        for (int v = 0; v < 2; v++) wr(1, v, 32'(v + 300), 32'(v + 303), 32'hFFFF_FFFF);
        run(4'b1010, 2, 1'b1);
        run(4'b1010, 2, 1'b0);
        rlat[3] = 0;

        // Reset while waiting on ch1, then rerun from the surviving store
        rdel[1] = 20;
        obs_q.delete();
        cur_en = 4'b0011;
        @(negedge clk);
        ch_en = 4'b0011; num_vec = 5'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 500 && found == 0; i++) begin
            for (int j = 0; j < obs_q.size(); j++)
                if (obs_q[j][35:32] == 4'd1 && stim_valid == 4'b0000) found = 1;
            if (found == 0) @(negedge clk);
        end
        chk("reached_wait_ch1", found, 1);
        chk("err_before_reset", err_count, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_stim_valid", stim_valid, 0);
        chk("midrst_err_count", err_count, 0);
        chk("midrst_first_err", first_err_valid, 0);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        run(4'b0011, 2, 1'b0);
        rdel[1] = 1;

        // Randomized runs
        noise_en = 1'b1;
        for (int it = 0; it < 12; it++) begin
            for (int c = 0; c < NCH; c++) begin
                rlat[c] = $urandom_range(0, 3);
                rdel[c] = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 4);
                for (int a = 0; a < DEPTH; a++) begin
                    logic [31:0] s, m, f;
                    s = $urandom;
                    m = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
                    f = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
                    wr(c, a, s, (s + 32'd3) ^ f, m);
                end
            end
            run(4'($urandom_range(0, 15)), $urandom_range(0, 20), 1'b0);
        end
        noise_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
